// File: rtl/std_ctrl_pkg.sv
// Shared definitions for go/done control blocks.
//   mem_copy_state_e : state encoding of the std_mem_d1 copy engine.
package std_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_WRITE = 2'd1,
        MC_WAIT  = 2'd2,
        MC_DONE  = 2'd3
    } mem_copy_state_e;

endpackage

// File: rtl/std_counter.sv
// Up-counter with synchronous clear and increment; clear has priority.
//   clk, reset : clock, synchronous active-high reset
//   clr        : load zero
//   inc        : add one (modulo 2^width)
//   out        : current count
module std_counter #(
    parameter int unsigned width = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] out
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // Next count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: rtl/std_mem_d1_copy.sv
// Go/done engine copying len consecutive words between two std_mem_d1
// instances, one word per WRITE/WAIT pair, ascending addresses.
//   clk, reset          : clock, synchronous active-high reset
//   go / done           : start request (held until done) / one-cycle completion
//   src_base, dst_base  : first addresses, sampled when go is accepted
//   len                 : word count 0..2^idx_size, sampled when go is accepted
//   src_addr0           : source read address
//   src_read_data       : source combinational read data
//   dst_addr0           : destination address
//   dst_write_data      : destination write data (wired from src_read_data)
//   dst_write_en        : destination write strobe, one cycle per word
//   dst_done            : destination write completion
module std_mem_d1_copy
    import std_ctrl_pkg::*;
#(
    parameter int unsigned width    = 32,
    parameter int unsigned size     = 16,
    parameter int unsigned idx_size = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [idx_size-1:0] src_base,
    input  logic [idx_size-1:0] dst_base,
    input  logic [idx_size:0]   len,
    output logic [idx_size-1:0] src_addr0,
    input  logic [width-1:0]    src_read_data,
    output logic [idx_size-1:0] dst_addr0,
    output logic [width-1:0]    dst_write_data,
    output logic                dst_write_en,
    input  logic                dst_done,
    output logic                done
);

    localparam int unsigned CW = idx_size + 1;

    // A memory deeper than the address space cannot be fully reached.
    if (size > (32'd1 << idx_size)) begin : g_bad_size
        $error("std_mem_d1_copy: size exceeds 2^idx_size");
    end

    mem_copy_state_e     state_q, state_d;
    logic [idx_size-1:0] src_q, src_d;
    logic [idx_size-1:0] dst_q, dst_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic                cnt_clr;
    logic                cnt_inc;

    std_counter #(.width(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .out   (cnt)
    );

    assign cnt_next = cnt + CW'(1);

    // Addresses wrap modulo 2^idx_size.
    assign src_addr0      = idx_size'(src_q + cnt[idx_size-1:0]);
    assign dst_addr0      = idx_size'(dst_q + cnt[idx_size-1:0]);
    assign dst_write_data = src_read_data;

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        dst_write_en = 1'b0;
        done         = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (go) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    len_d   = len;
                    cnt_clr = 1'b1;
                    state_d = (len == '0) ? MC_DONE : MC_WRITE;
                end
            end
            MC_WRITE: begin
                dst_write_en = 1'b1;
                state_d      = MC_WAIT;
            end
            MC_WAIT: begin
                if (dst_done) begin
                    cnt_inc = 1'b1;
                    state_d = (cnt_next == len_q) ? MC_DONE : MC_WRITE;
                end
            end
            MC_DONE: begin
                done    = 1'b1;
                state_d = MC_IDLE;
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    // State and sampled-operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MC_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Directed bench for std_mem_d1_copy with behavioural source/destination
// memories; destination done latency is programmable.
module tb_std_mem_d1_copy;

    logic        clk;
    logic        reset;
    logic        go;
    logic [3:0]  src_base;
    logic [3:0]  dst_base;
    logic [4:0]  len;
    logic [3:0]  src_addr0;
    logic [31:0] src_read_data;
    logic [3:0]  dst_addr0;
    logic [31:0] dst_write_data;
    logic        dst_write_en;
    logic        dst_done;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] src_mem [16];
    logic [31:0] dst_mem [16];
    int          pend = 0;
    int          done_dly = 1;
    logic        stray_done = 1'b0;
    logic        same_mem = 1'b0;
    logic        mdl_init = 1'b0;

    std_mem_d1_copy #(.width(32), .size(16), .idx_size(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .len            (len),
        .src_addr0      (src_addr0),
        .src_read_data  (src_read_data),
        .dst_addr0      (dst_addr0),
        .dst_write_data (dst_write_data),
        .dst_write_en   (dst_write_en),
        .dst_done       (dst_done),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational read, write on posedge, done after done_dly cycles.
    assign src_read_data = same_mem ? dst_mem[src_addr0] : src_mem[src_addr0];
    assign dst_done      = (pend == 1) || stray_done;

    always @(posedge clk) begin
        if (mdl_init) begin
            for (int i = 0; i < 16; i++) dst_mem[i] <= 32'hDEAD0000 + 32'(i);
        end else if (dst_write_en) begin
            dst_mem[dst_addr0] <= dst_write_data;
        end
        if (dst_write_en) pend <= done_dly;
        else if (pend > 0) pend <= pend - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one copy; returns cycles from accept to done (-1 on timeout) and write count.
    task automatic run_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                            output int lat, output int wen);
        @(negedge clk);
        src_base = s;
        dst_base = d;
        len      = l;
        go       = 1'b1;
        @(posedge clk);
        lat = -1;
        wen = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                src_base = ~s;
                dst_base = ~d;
                len      = 5'd1;
            end
            if (dst_write_en) wen++;
            if (done) begin
                lat = c;
                go  = 1'b0;
                break;
            end
        end
        go = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wen;
        int seen;

        for (int i = 0; i < 16; i++) src_mem[i] = 32'h100 + 32'(i);
        src_mem[0] = 32'd10;
        src_mem[1] = 32'd11;
        src_mem[2] = 32'd12;
        src_mem[3] = 32'd13;

        reset    = 1'b1;
        mdl_init = 1'b1;
        go       = 1'b0;
        src_base = 4'd9;
        dst_base = 4'd9;
        len      = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wen", 32'(dst_write_en), 32'd0);
        chk("rst_src_addr", 32'(src_addr0), 32'd0);
        chk("rst_dst_addr", 32'(dst_addr0), 32'd0);
        mdl_init = 1'b0;
        reset    = 1'b0;

        // Basic copy 0..3 -> 4..7.
        run_copy(4'd0, 4'd4, 5'd4, lat, wen);
        chk("basic_lat", 32'(lat), 32'd9);
        chk("basic_wen", 32'(wen), 32'd4);
        chk("basic_d4", dst_mem[4], 32'd10);
        chk("basic_d5", dst_mem[5], 32'd11);
        chk("basic_d6", dst_mem[6], 32'd12);
        chk("basic_d7", dst_mem[7], 32'd13);

        // Zero length.
        run_copy(4'd2, 4'd8, 5'd0, lat, wen);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_wen", 32'(wen), 32'd0);
        chk("zero_d8", dst_mem[8], 32'hDEAD0008);

        // Wrap-around source 14,15,0,1 -> 0..3.
        run_copy(4'd14, 4'd0, 5'd4, lat, wen);
        chk("wrap_lat", 32'(lat), 32'd9);
        chk("wrap_d0", dst_mem[0], 32'h10E);
        chk("wrap_d1", dst_mem[1], 32'h10F);
        chk("wrap_d2", dst_mem[2], 32'd10);
        chk("wrap_d3", dst_mem[3], 32'd11);

        // Stray dst_done in IDLE must not start anything.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        seen = 0;
        repeat (3) begin
            if (dst_write_en || done) seen++;
            @(negedge clk);
        end
        chk("stray_idle", 32'(seen), 32'd0);

        // Slow destination: done 3 cycles after write_en.
        done_dly = 3;
        run_copy(4'd4, 4'd8, 5'd2, lat, wen);
        chk("slow_lat", 32'(lat), 32'd9);
        chk("slow_wen", 32'(wen), 32'd2);
        chk("slow_d8", dst_mem[8], 32'h104);
        chk("slow_d9", dst_mem[9], 32'h105);

        // Reset during the second WAIT of a len=4 copy (slow destination).
        @(negedge clk);
        src_base = 4'd0;
        dst_base = 4'd12;
        len      = 5'd4;
        go       = 1'b1;
        @(posedge clk);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        go    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_wen", 32'(dst_write_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_dst_addr", 32'(dst_addr0), 32'd0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (dst_write_en || done) seen++;
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        chk("mid_rst_d12", dst_mem[12], 32'd10);
        chk("mid_rst_d13", dst_mem[13], 32'd11);
        chk("mid_rst_d14", dst_mem[14], 32'hDEAD000E);
        chk("mid_rst_d15", dst_mem[15], 32'hDEAD000F);

        done_dly = 1;
        run_copy(4'd0, 4'd12, 5'd4, lat, wen);
        chk("after_rst_lat", 32'(lat), 32'd9);
        chk("after_rst_d14", dst_mem[14], 32'd12);
        chk("after_rst_d15", dst_mem[15], 32'd13);

        // Full-length copy of all 16 words.
        run_copy(4'd0, 4'd0, 5'd16, lat, wen);
        chk("full_lat", 32'(lat), 32'd33);
        chk("full_wen", 32'(wen), 32'd16);
        chk("full_d0", dst_mem[0], 32'd10);
        chk("full_d5", dst_mem[5], 32'h105);
        chk("full_d15", dst_mem[15], 32'h10F);

        // Overlapping copy within one memory: forward propagation of word 0.
        same_mem = 1'b1;
        run_copy(4'd0, 4'd1, 5'd3, lat, wen);
        chk("ovl_lat", 32'(lat), 32'd7);
        chk("ovl_d1", dst_mem[1], 32'd10);
        chk("ovl_d2", dst_mem[2], 32'd10);
        chk("ovl_d3", dst_mem[3], 32'd10);
        chk("ovl_d4", dst_mem[4], 32'h104);
        same_mem = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
